// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between N_REQ byte producers,
// with optional packet lock and a watchdog that recovers from a missing done pulse.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned CLK_HZ       = 25000000,
  parameter int unsigned LOCK_EN      = 1,
  parameter int unsigned TIMEOUT_BITS = 11,
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               i_Clk,
  input  logic               i_reset_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_lock_active,
  output logic               o_timeout
);

  localparam int unsigned CLK_PER_BIT    = CLK_HZ / BAUD_RATE;
  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int unsigned WDW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT    = WDW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [WDW-1:0]   wd;
  logic [N_REQ-1:0] lock_mask;
  logic [N_REQ-1:0] eligible;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic [7:0]       win_data;
  logic             win_last;
  logic             grant_ok;

  // While locked only the last accepted requester may compete.
  always_comb begin
    lock_mask = '0;
    for (int unsigned j = 0; j < N_REQ; j++)
      lock_mask[j] = (o_grant_id == IDW'(j));
    eligible = o_lock_active ? (i_req_valid & lock_mask) : i_req_valid;
  end

  // Search starts one past the previous winner and wraps modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDW'((32'(ptr) + i) % N_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data    = '0;
    win_last    = 1'b0;
    o_req_ready = '0;
    grant_ok    = (state == S_IDLE) && win_found && !i_tx_busy && i_reset_n;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (win_idx == IDW'(j)) begin
        win_data       = i_req_data[8*j +: 8];
        win_last       = i_req_last[j];
        o_req_ready[j] = grant_ok;
      end
    end
  end

  assign o_tx_start = (state == S_START);

  always_ff @(posedge i_Clk) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      ptr           <= IDW'(N_REQ - 1);
      wd            <= '0;
      o_tx_data     <= '0;
      o_grant_id    <= '0;
      o_lock_active <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            o_tx_data     <= win_data;
            ptr           <= win_idx;
            o_grant_id    <= win_idx;
            o_lock_active <= (LOCK_EN != 0) ? ~win_last : 1'b0;
            state         <= S_START;
          end
        end
        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over a coincident watchdog expiry.
          if (i_tx_done) begin
            wd    <= '0;
            state <= S_IDLE;
          end else if (wd == WD_LIMIT) begin
            wd            <= '0;
            o_timeout     <= 1'b1;
            o_lock_active <= 1'b0;
            state         <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one locking and one non-locking instance share
// the same requesters and a hand-driven transmitter done/busy.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic        tx_busy;
  logic        tx_done;

  logic [2:0]  ready_a, ready_b;
  logic        start_a, start_b;
  logic [7:0]  data_a, data_b;
  logic [1:0]  grant_a, grant_b;
  logic        lock_a, lock_b;
  logic        tmo_a, tmo_b;

  int n_vec  = 0;
  int n_miss = 0;
  int n_start_b = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(3), .BAUD_RATE(115200), .CLK_HZ(25000000),
                    .LOCK_EN(1), .TIMEOUT_BITS(11)) dut (
    .i_Clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(ready_a), .o_tx_start(start_a),
    .o_tx_data(data_a), .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_grant_id(grant_a), .o_lock_active(lock_a), .o_timeout(tmo_a));

  uart_tx_arbiter #(.N_REQ(3), .BAUD_RATE(115200), .CLK_HZ(25000000),
                    .LOCK_EN(0), .TIMEOUT_BITS(11)) dut_rr (
    .i_Clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(ready_b), .o_tx_start(start_b),
    .o_tx_data(data_b), .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_grant_id(grant_b), .o_lock_active(lock_b), .o_timeout(tmo_b));

  always @(negedge clk) if (start_b) n_start_b = n_start_b + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the START cycle: hold off gap cycles, then pulse done; returns in IDLE.
  task automatic serve(input int unsigned gap);
    for (int unsigned c = 0; c < gap; c++) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [2:0] rr_rdy_b [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] rr_gnt_b [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [7:0] rr_dat_b [4] = '{8'h11, 8'h22, 8'h33, 8'h11};

  logic [7:0] lk_d1    [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA2};
  logic       lk_l1    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] lk_rdy_a [4] = '{3'b010, 3'b010, 3'b010, 3'b100};
  logic [1:0] lk_gnt_a [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
  logic [7:0] lk_dat_a [4] = '{8'hA0, 8'hA1, 8'hA2, 8'h33};
  logic       lk_lck_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] lk_rdy_b [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  logic [1:0] lk_gnt_b [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  logic [7:0] lk_dat_b [4] = '{8'hA0, 8'h33, 8'h11, 8'hA2};

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    int early;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    tick(); tick();

    // reset state
    check_eq("rst_ready",  ready_a, 3'b000);
    check_eq("rst_start",  start_a, 1'b0);
    check_eq("rst_data",   data_a, 8'h00);
    check_eq("rst_grant",  grant_a, 2'd0);
    check_eq("rst_lock",   lock_a, 1'b0);
    check_eq("rst_tmo",    tmo_a, 1'b0);
    rst_n = 1'b1;
    tick();

    // single byte with full-length transmitter
    req_valid = 3'b001; req_data = {8'h33, 8'h22, 8'hB2}; req_last = 3'b001;
    #1;
    check_eq("t1_ready", ready_a, 3'b001);
    check_eq("t1_ready_rr", ready_b, 3'b001);
    tick();
    check_eq("t1_start", start_a, 1'b1);
    check_eq("t1_data", data_a, 8'hB2);
    check_eq("t1_grant", grant_a, 2'd0);
    check_eq("t1_lock", lock_a, 1'b0);
    req_valid = 3'b000;
    tick();
    check_eq("t1_start_once", start_a, 1'b0);
    req_valid = 3'b001;
    for (int c = 0; c < 2169; c++) tick();
    check_eq("t1_wait_ready", ready_a, 3'b000);
    check_eq("t1_data_hold", data_a, 8'hB2);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("t1_idle_ready", ready_a, 3'b001);
    req_valid = 3'b000;

    // round robin on the non-locking instance; locking instance stays on req0
    pulse_reset();
    base = n_start_b;
    req_data = {8'h33, 8'h22, 8'h11}; req_last = 3'b000; req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_ready_b", ready_b, rr_rdy_b[i]);
      check_eq("rr_ready_a", ready_a, 3'b001);
      tick();
      check_eq("rr_start_b", start_b, 1'b1);
      check_eq("rr_grant_b", grant_b, rr_gnt_b[i]);
      check_eq("rr_data_b", data_b, rr_dat_b[i]);
      check_eq("rr_lock_b", lock_b, 1'b0);
      check_eq("rr_grant_a", grant_a, 2'd0);
      check_eq("rr_lock_a", lock_a, 1'b1);
      serve(5);
    end
    check_eq("rr_start_count", n_start_b - base, 4);
    req_valid = 3'b000;

    // packet lock: req1 sends three bytes while req0/req2 also request
    pulse_reset();
    req_valid = 3'b001; req_last = 3'b111; req_data = {8'h33, 8'hA0, 8'h11};
    #1;
    tick();
    serve(5);
    for (int i = 0; i < 4; i++) begin
      req_data[15:8] = lk_d1[i];
      req_last = {1'b1, lk_l1[i], 1'b1};
      req_valid = 3'b111;
      #1;
      check_eq("lk_ready_a", ready_a, lk_rdy_a[i]);
      check_eq("lk_ready_b", ready_b, lk_rdy_b[i]);
      tick();
      check_eq("lk_start_a", start_a, 1'b1);
      check_eq("lk_grant_a", grant_a, lk_gnt_a[i]);
      check_eq("lk_data_a", data_a, lk_dat_a[i]);
      check_eq("lk_lock_a", lock_a, lk_lck_a[i]);
      check_eq("lk_grant_b", grant_b, lk_gnt_b[i]);
      check_eq("lk_data_b", data_b, lk_dat_b[i]);
      check_eq("lk_lock_b", lock_b, 1'b0);
      serve(5);
    end

    // busy gating
    req_valid = 3'b001; req_last = 3'b111; tx_busy = 1'b1;
    #1;
    check_eq("busy_ready_a", ready_a, 3'b000);
    check_eq("busy_ready_b", ready_b, 3'b000);
    tick();
    check_eq("busy_ready_a2", ready_a, 3'b000);
    check_eq("busy_start_a", start_a, 1'b0);
    tick();
    tx_busy = 1'b0;
    #1;
    check_eq("unbusy_ready_a", ready_a, 3'b001);
    check_eq("unbusy_ready_b", ready_b, 3'b001);
    tick();
    check_eq("unbusy_start_a", start_a, 1'b1);
    check_eq("unbusy_data_a", data_a, 8'h11);
    check_eq("unbusy_grant_a", grant_a, 2'd0);
    req_valid = 3'b000;
    serve(5);

    // watchdog: no done ever arrives
    req_valid = 3'b010; req_last = 3'b000; req_data[15:8] = 8'hA5;
    #1;
    check_eq("wd_ready_a", ready_a, 3'b010);
    tick();
    check_eq("wd_lock_a", lock_a, 1'b1);
    check_eq("wd_lock_b", lock_b, 1'b0);
    check_eq("wd_data_a", data_a, 8'hA5);
    req_valid = 3'b101;
    tick();
    early = 0;
    for (int c = 1; c <= 2387; c++) begin
      tick();
      if (c == 10) check_eq("wd_wait_ready", ready_a, 3'b000);
      if (c < 2387 && (tmo_a || tmo_b)) early++;
    end
    check_eq("wd_early", early, 0);
    check_eq("wd_tmo_a", tmo_a, 1'b1);
    check_eq("wd_tmo_b", tmo_b, 1'b1);
    check_eq("wd_lock_clr", lock_a, 1'b0);
    check_eq("wd_next_ready_a", ready_a, 3'b100);
    check_eq("wd_next_ready_b", ready_b, 3'b100);
    tick();
    check_eq("wd_tmo_pulse", tmo_a, 1'b0);
    check_eq("wd_next_start", start_a, 1'b1);
    check_eq("wd_next_data", data_a, 8'h33);
    req_valid = 3'b000;

    // reset during WAIT_DONE
    tick(); tick(); tick(); tick();
    req_valid = 3'b111;
    rst_n = 1'b0;
    tick();
    check_eq("mr_start", start_a, 1'b0);
    check_eq("mr_data", data_a, 8'h00);
    check_eq("mr_grant", grant_a, 2'd0);
    check_eq("mr_lock", lock_a, 1'b0);
    check_eq("mr_tmo", tmo_a, 1'b0);
    check_eq("mr_ready_a", ready_a, 3'b000);
    check_eq("mr_ready_b", ready_b, 3'b000);
    rst_n = 1'b1;
    #1;
    check_eq("mr_first_a", ready_a, 3'b001);
    check_eq("mr_first_b", ready_b, 3'b001);
    tick();
    check_eq("mr_start_after", start_a, 1'b1);
    check_eq("mr_data_after", data_a, 8'h11);
    req_valid = 3'b000;
    serve(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
